// File: rtl/ne_fp_add_pkg.sv
// Shared constants for the ne_fp_add adder-sharing block: default operand/result
// widths, adder mode encodings and status-field bit positions.
package ne_fp_add_pkg;

  localparam int BWA_DEF = 41;
  localparam int BWZ_DEF = 42;

  localparam logic [2:0] MODE_TF32 = 3'b100;
  localparam logic [2:0] MODE_FP8  = 3'b010;
  localparam logic [2:0] MODE_INT8 = 3'b001;

  localparam int ST_NAN  = 2;
  localparam int ST_INF  = 1;
  localparam int ST_ZERO = 0;

endpackage

// File: rtl/ne_fp_add_arb_chk.sv
// Invariant checker for the arbiter's response buffer and credit counter.
module ne_fp_add_arb_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] count_i,
  input logic [CW-1:0] credit_i
);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count_i == CW'(DEPTH))));

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && (count_i == '0)));

  a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
    credit_i <= CW'(DEPTH));

endmodule

// File: rtl/ne_fp_add_arb_rsp_fifo.sv
// Response FIFO: the head entry lives in its own output register, the remaining
// DEPTH-1 entries sit in a small ring behind it.
module ne_fp_add_arb_rsp_fifo
  import ne_fp_add_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int MD   = DEPTH - 1,
  localparam int PW   = (MD > 1) ? $clog2(MD) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic          vld_o,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [MD];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d, mem_cnt_s;
  logic [W-1:0]  out_q;
  logic          vld_q, pop_s;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(MD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop_s     = pop_i & vld_q;
    mem_cnt_s = count_q - {{(CW-1){1'b0}}, vld_q};
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Head register refills from the ring on pop, or directly from din when the ring is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pop_s) begin
        if (mem_cnt_s != '0) begin
          out_q <= mem_q[rd_q];
          rd_q  <= ptr_nxt(rd_q);
          if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ptr_nxt(wr_q);
          end
        end else if (push_i) begin
          out_q <= din_i;
        end else begin
          vld_q <= 1'b0;
        end
      end else if (push_i) begin
        if (!vld_q) begin
          out_q <= din_i;
          vld_q <= 1'b1;
        end else begin
          mem_q[wr_q] <= din_i;
          wr_q        <= ptr_nxt(wr_q);
        end
      end
    end
  end

  assign vld_o   = vld_q;
  assign dout_o  = out_q;
  assign count_o = count_q;

endmodule

// File: rtl/ne_fp_add_arb.sv
// Round-robin sharing of one pipelined adder among N_REQ requesters, with an
// in-order, credit-protected response FIFO.
module ne_fp_add_arb
  import ne_fp_add_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BWA   = BWA_DEF,
  parameter int BWZ   = BWZ_DEF,
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_vld_i,
  output logic [N_REQ-1:0]     req_rdy_o,
  input  logic [N_REQ*BWA-1:0] req_a_i,
  input  logic [N_REQ*BWA-1:0] req_b_i,
  input  logic [N_REQ*3-1:0]   req_mode_i,
  output logic [BWA-1:0]       add_a_o,
  output logic [BWA-1:0]       add_b_o,
  output logic [2:0]           add_mode_o,
  input  logic [BWZ-1:0]       add_z_i,
  output logic                 rsp_vld_o,
  input  logic                 rsp_rdy_i,
  output logic [IW-1:0]        rsp_id_o,
  output logic [BWZ-1:0]       rsp_z_o,
  output logic                 busy_o
);

  logic [IW-1:0]  rr_q, rr_d, win_s;
  logic [CW-1:0]  credit_q, credit_d, fifo_cnt_s;
  logic [BWA-1:0] add_a_q, add_b_q, add_a_s, add_b_s;
  logic [2:0]     mode_q, mode_s;
  logic           issue_s, pop_s;
  logic [N_REQ-1:0] rdy_s;
  logic [LAT-1:0] tv_q;
  logic [IW-1:0]  tid_q [LAT];

  // First valid requester at or above ptr, wrapping past N_REQ-1.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] idx;
    logic          found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && vld[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
    end
  endfunction

  always_comb begin
    win_s   = rr_pick(req_vld_i, rr_q);
    issue_s = (credit_q != '0) && (|req_vld_i);
    rdy_s   = '0;
    add_a_s = add_a_q;
    add_b_s = add_b_q;
    mode_s  = mode_q;
    rr_d    = rr_q;
    if (issue_s) begin
      rdy_s[win_s] = 1'b1;
      add_a_s      = req_a_i[win_s*BWA +: BWA];
      add_b_s      = req_b_i[win_s*BWA +: BWA];
      mode_s       = req_mode_i[win_s*3 +: 3];
      rr_d         = (win_s == IW'(N_REQ - 1)) ? '0 : win_s + IW'(1);
    end else begin
      rdy_s = '0;
    end
    // A pop never frees a slot for an issue in the same cycle.
    case ({issue_s, pop_s})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      credit_q <= CW'(DEPTH);
      add_a_q  <= '0;
      add_b_q  <= '0;
      mode_q   <= 3'b000;
      tv_q     <= '0;
      for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      credit_q <= credit_d;
      add_a_q  <= add_a_s;
      add_b_q  <= add_b_s;
      mode_q   <= mode_s;
      tv_q[0]  <= issue_s;
      tid_q[0] <= win_s;
      for (int i = 1; i < LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  assign pop_s = rsp_vld_o & rsp_rdy_i;

  ne_fp_add_arb_rsp_fifo #(.W(IW + BWZ), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tv_q[LAT-1]),
    .din_i   ({tid_q[LAT-1], add_z_i}),
    .pop_i   (rsp_rdy_i),
    .vld_o   (rsp_vld_o),
    .dout_o  ({rsp_id_o, rsp_z_o}),
    .count_o (fifo_cnt_s)
  );

  ne_fp_add_arb_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (tv_q[LAT-1]),
    .pop_i    (pop_s),
    .count_i  (fifo_cnt_s),
    .credit_i (credit_q)
  );

  assign req_rdy_o  = rdy_s;
  assign add_a_o    = add_a_s;
  assign add_b_o    = add_b_s;
  assign add_mode_o = mode_s;
  assign busy_o     = (credit_q != CW'(DEPTH));

endmodule
